// File: rtl/dram_pkg.sv
// Shared encodings and index-width helpers for the DRAM controller and responder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dram_pkg;

  // Command encodings on the 2-bit cmd bus.
  typedef enum logic [1:0] {
    CMD_ACT = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_PRE = 2'b11
  } cmd_t;

  // Responder handshake states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ_WAIT = 2'b01,
    ST_ACKED    = 2'b10,
    ST_REL_WAIT = 2'b11
  } resp_state_t;

  // Index width for an n-entry one-hot select; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DRAM_NUM_OF_BANKS = 8;
  localparam int DRAM_NUM_OF_ROWS  = 128;
  localparam int DRAM_NUM_OF_COLS  = 8;

  localparam int DRAM_BANK_IDX_W = idx_w(DRAM_NUM_OF_BANKS);
  localparam int DRAM_ROW_IDX_W  = idx_w(DRAM_NUM_OF_ROWS);
  localparam int DRAM_COL_IDX_W  = idx_w(DRAM_NUM_OF_COLS);

endpackage

// File: rtl/dram_cmd_responder_if.sv
// Four-phase command bus between dram_ctrl (master) and the responder (slave).
// Latency: none (wires only).
// Backpressure: the slave holds cmd_ack until the master releases cmd_req.
interface dram_cmd_responder_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);

  logic                    cmd_req;
  logic [1:0]              cmd;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic                    cmd_ack;
  logic                    cmd_err;
  logic [NUM_OF_BANKS-1:0] open_bank;

  modport master (
    output cmd_req, cmd, bank_sel, row_sel, col_sel,
    input  cmd_ack, cmd_err, open_bank
  );

  modport slave (
    input  cmd_req, cmd, bank_sel, row_sel, col_sel,
    output cmd_ack, cmd_err, open_bank
  );

endinterface

// File: rtl/dram_cmd_responder_onehot_decoder.sv
// One-hot select to binary index, with a flag that the select is exactly one-hot.
// Latency: combinational.
// Backpressure: not applicable.
module onehot_decoder
  import dram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] sel,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);

  // OR together the indices of set bits; only meaningful when is_onehot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    is_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  end

endmodule

// File: rtl/dram_cmd_responder.sv
// Memory-side endpoint for the four-phase cmd_req/cmd_ack handshake: open-row tracking and 1-bit storage.
// Latency: ack ACK_DELAY cycles after req is sampled high, release ACK_DELAY cycles after req is sampled low.
// Backpressure: ack is held until req drops; a new request is only taken in IDLE.
module dram_cmd_responder
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = DRAM_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DRAM_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DRAM_NUM_OF_COLS,
  parameter int ACK_DELAY    = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  dram_cmd_responder_if.slave cmd_if,
  inout  wire                 dram_data
);

  localparam int BANK_W = idx_w(NUM_OF_BANKS);
  localparam int ROW_W  = idx_w(NUM_OF_ROWS);
  localparam int COL_W  = idx_w(NUM_OF_COLS);
  localparam int DEPTH  = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
  localparam int ADDR_W = idx_w(DEPTH);
  localparam int CNT_W  = $clog2(ACK_DELAY + 1);

  resp_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  cmd_t                    cmd_q, cmd_d;
  logic [NUM_OF_BANKS-1:0] bank_sel_q, bank_sel_d;
  logic [NUM_OF_ROWS-1:0]  row_sel_q, row_sel_d;
  logic [NUM_OF_COLS-1:0]  col_sel_q, col_sel_d;
  logic                    cmd_ack_q, cmd_ack_d;
  logic                    cmd_err_q, cmd_err_d;
  logic                    dout_q, dout_d;
  logic [NUM_OF_BANKS-1:0] open_bank_q, open_bank_d;
  logic [ROW_W-1:0]        open_row_q [NUM_OF_BANKS];
  logic [ROW_W-1:0]        open_row_d [NUM_OF_BANKS];

  // Storage is deliberately not reset; contents survive rst_b.
  logic                    mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;

  logic [BANK_W-1:0]       bank_idx;
  logic [ROW_W-1:0]        row_idx;
  logic [COL_W-1:0]        col_idx;
  logic                    bank_oh, row_oh, col_oh;
  logic                    bank_open, row_hit, act_ok, rw_ok;
  logic                    rd_drive;

  // Decoders work on the latched selects so later bus changes are ignored.
  onehot_decoder #(.WIDTH(NUM_OF_BANKS), .IDX_W(BANK_W)) u_bank_dec (
    .sel(bank_sel_q), .idx(bank_idx), .is_onehot(bank_oh)
  );
  onehot_decoder #(.WIDTH(NUM_OF_ROWS), .IDX_W(ROW_W)) u_row_dec (
    .sel(row_sel_q), .idx(row_idx), .is_onehot(row_oh)
  );
  onehot_decoder #(.WIDTH(NUM_OF_COLS), .IDX_W(COL_W)) u_col_dec (
    .sel(col_sel_q), .idx(col_idx), .is_onehot(col_oh)
  );

  // Legality of the latched command against the current open-row table.
  always_comb begin
    bank_open = open_bank_q[bank_idx];
    row_hit   = row_oh && (row_idx == open_row_q[bank_idx]);
    act_ok    = bank_oh && row_oh && !bank_open;
    rw_ok     = bank_oh && bank_open && row_hit && col_oh;
    mem_addr  = ADDR_W'(bank_idx) * ADDR_W'(NUM_OF_ROWS * NUM_OF_COLS)
              + ADDR_W'(row_idx) * ADDR_W'(NUM_OF_COLS)
              + ADDR_W'(col_idx);
  end

  // Handshake sequencing; the command takes effect on the ack edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    bank_sel_d  = bank_sel_q;
    row_sel_d   = row_sel_q;
    col_sel_d   = col_sel_q;
    cmd_ack_d   = cmd_ack_q;
    cmd_err_d   = cmd_err_q;
    dout_d      = dout_q;
    open_bank_d = open_bank_q;
    open_row_d  = open_row_q;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_if.cmd_req) begin
          cmd_d      = cmd_t'(cmd_if.cmd);
          bank_sel_d = cmd_if.bank_sel;
          row_sel_d  = cmd_if.row_sel;
          col_sel_d  = cmd_if.col_sel;
          cnt_d      = CNT_W'(1);
          state_d    = ST_REQ_WAIT;
        end
      end
      ST_REQ_WAIT: begin
        // A request dropped early is ignored here; the transaction still acks.
        if (cnt_q == CNT_W'(ACK_DELAY)) begin
          state_d   = ST_ACKED;
          cmd_ack_d = 1'b1;
          case (cmd_q)
            CMD_ACT: begin
              cmd_err_d = !act_ok;
              if (act_ok) begin
                open_bank_d[bank_idx] = 1'b1;
                open_row_d[bank_idx]  = row_idx;
              end
            end
            CMD_RD: begin
              cmd_err_d = !rw_ok;
              dout_d    = rw_ok ? mem_q[mem_addr] : 1'b0;
            end
            CMD_WR: begin
              cmd_err_d = !rw_ok;
              mem_we    = rw_ok;
            end
            CMD_PRE: begin
              // Closing an already closed bank is harmless; only an empty select is wrong.
              cmd_err_d   = (bank_sel_q == '0);
              open_bank_d = open_bank_q & ~bank_sel_q;
            end
            default: begin
              cmd_err_d = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACKED: begin
        if (!cmd_if.cmd_req) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_REL_WAIT;
        end
      end
      ST_REL_WAIT: begin
        if (cnt_q == CNT_W'(ACK_DELAY)) begin
          cmd_ack_d = 1'b0;
          cmd_err_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= CMD_ACT;
      bank_sel_q  <= '0;
      row_sel_q   <= '0;
      col_sel_q   <= '0;
      cmd_ack_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      dout_q      <= 1'b0;
      open_bank_q <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        open_row_q[b] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      bank_sel_q  <= bank_sel_d;
      row_sel_q   <= row_sel_d;
      col_sel_q   <= col_sel_d;
      cmd_ack_q   <= cmd_ack_d;
      cmd_err_q   <= cmd_err_d;
      dout_q      <= dout_d;
      open_bank_q <= open_bank_d;
      open_row_q  <= open_row_d;
    end
  end

  // Write data is taken from the shared line exactly on the ack edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= dram_data;
    end
  end

  // Drive the shared line only while a read is acknowledged.
  assign rd_drive  = ((state_q == ST_ACKED) || (state_q == ST_REL_WAIT)) && (cmd_q == CMD_RD);
  assign dram_data = rd_drive ? dout_q : 1'bz;

  assign cmd_if.cmd_ack   = cmd_ack_q;
  assign cmd_if.cmd_err   = cmd_err_q;
  assign cmd_if.open_bank = open_bank_q;

endmodule
